mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Arbitrates the CPU's two sram-like memory requesters onto one downstream sram-like port: instruction fetch (IF stage, read-only) and data access (MEM stage, load/store). At most one transaction is outstanding at a time. Data has fixed priority, and a bounded-starvation counter guarantees fetch progress. The block sits between the pipeline's memory interfaces and the bus bridge/cache. Its addr_ok/data_ok returns feed the pipeline stall logic.

## Interface
- STARVE_LIMIT, default 4: consecutive data grants allowed while a fetch is waiting before fetch is forced; must be ≥1.
- clk  in  1  clock; all state updates on the rising edge
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  fetch request
- inst_addr  in  32  fetch address (always wr=0, size=2'd2, wstrb=4'h0 downstream)
- inst_addr_ok  out  1  fetch request accepted
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  32  fetch data
- data_req  in  1  data request
- data_wr  in  1  1 = store
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  byte enables for stores
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  load data valid / store complete
- data_rdata  out  32  load data
- req, wr, size[1:0], wstrb[3:0], addr[31:0], wdata[31:0]  out  downstream request fields
- addr_ok, data_ok  in  1  downstream handshake
- rdata  in  32  downstream read data

## Operation
- State machine states:
  - IDLE: no downstream activity.
  - REQ: downstream req=1 for the granted owner.
  - WAIT: request accepted; awaiting data_ok.
- A 1-bit owner register records the granted requester: 0 = inst, 1 = data.
- Grant decision happens in IDLE only.
  - Only one requester pending: grant it.
  - Both pending: grant data, unless starve_cnt == STARVE_LIMIT, in which case grant inst.
  - On any grant, go to REQ next cycle.
- starve_cnt, width $clog2(STARVE_LIMIT+1), changes only on a grant:
  - Data granted with inst_req=1: increment, saturating at STARVE_LIMIT.
  - Any other grant: clear to 0.
- REQ: downstream fields are driven combinationally from the owner's inputs; inst fields are forced as above.
  - The requester must hold req and all fields stable until its addr_ok.
  - On addr_ok with data_ok: go to IDLE.
  - On addr_ok without data_ok: go to WAIT.
  - Otherwise stay in REQ.
- WAIT: on data_ok, go to IDLE.
- Return routing:
  - owner_addr_ok = addr_ok & (state==REQ) & owner match.
  - owner_data_ok = data_ok & (state is REQ with addr_ok, or WAIT) & owner match.
  - The non-owner's ok signals are 0.
  - inst_rdata and data_rdata both equal rdata unconditionally; consumers qualify them with data_ok.
- Downstream data_ok arriving in IDLE, or in REQ without addr_ok, is a protocol error. It is ignored and nothing is forwarded.
- A requester dropping req before addr_ok is illegal; the block keeps issuing the latched owner's fields.
- Reset, including mid-transaction, does the following:
  - state = IDLE, owner = 0, starve_cnt = 0.
  - Any outstanding transaction is abandoned; the downstream must share resetn.

## Timing
- Reset values of outputs:
  - req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok = 0.
  - wr, size, wstrb, addr, wdata follow owner 0, i.e. inst fields; req=0 qualifies them.
- Grant latency: request seen in IDLE at cycle N; downstream req=1 at cycle N+1.
- Acceptance and data:
  - addr_ok/data_ok pass to the requester in the same cycle; there is no registered return path.
  - Minimum transaction is 2 cycles (IDLE, then REQ with addr_ok and data_ok). Peak throughput is one transaction per 2 cycles.
- A request arriving while another transaction is in flight waits; it is reconsidered in the first IDLE cycle after data_ok.
- STARVE_LIMIT=1 alternates data and inst under continuous contention.

## Test plan
- Single fetch: inst_req=1, addr=0xBFC00000; downstream addr_ok in 1st REQ cycle, data_ok 3 cycles later with rdata=0x3C1DBFC0.
  - Required: req=1 with wr=0, size=2, addr=0xBFC00000.
  - Required: inst_data_ok=1 exactly once with inst_rdata=0x3C1DBFC0.
  - Required: data_* ok signals stay 0.
- Simultaneous requests: both req=1 in IDLE.
  - Required: data is granted first.
  - Required: inst is granted in the IDLE cycle after data's data_ok.
- Starvation: STARVE_LIMIT=4, data_req held high continuously along with inst_req.
  - Required: grant sequence D,D,D,D,I,D,D,D,D,I.
  - Required: starve_cnt returns to 0 after each I.
- Store pass-through: data_wr=1, size=0, wstrb=4'b0100, addr=0x80001002, wdata=0x00AB0000; downstream addr_ok held low 2 cycles.
  - Required: fields are stable on the downstream port for 3 REQ cycles.
  - Required: data_addr_ok pulses once.
- Zero-wait: addr_ok and data_ok both high in the first REQ cycle.
  - Required: ok signals pulse in the same cycle; IDLE follows.
  - Required: back-to-back fetches complete every 2 cycles.
- Reset mid-WAIT: resetn low asynchronously while in WAIT, then released.
  - Required: req and all ok outputs are 0 immediately.
  - Required: a stale data_ok after reset is not forwarded.
  - Required: the next request proceeds normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single sram-like port with one
// transaction in flight, fixed data priority and bounded fetch starvation.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction fetch requester
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data requester
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // downstream port
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [3:0]  wstrb,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             owner, owner_nxt;     // 0 = inst, 1 = data
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             fwd_addr_ok, fwd_data_ok;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    starve_nxt = starve_cnt;
    unique case (state)
      IDLE: begin
        if (inst_req || data_req) begin
          state_nxt = REQ;
          if (data_req && !(inst_req && starve_cnt == CNT_MAX)) begin
            owner_nxt  = 1'b1;
            // A data win over a waiting fetch implies starve_cnt < CNT_MAX,
            // so the increment saturates by construction.
            starve_nxt = inst_req ? starve_cnt + 1'b1 : '0;
          end else begin
            owner_nxt  = 1'b0;
            starve_nxt = '0;
          end
        end
      end
      REQ: begin
        if (addr_ok) state_nxt = data_ok ? IDLE : WAIT;
      end
      WAIT: begin
        if (data_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch is always a read of a full word with no byte enables.
  assign req   = (state == REQ);
  assign wr    = owner & data_wr;
  assign size  = owner ? data_size  : 2'd2;
  assign wstrb = owner ? data_wstrb : 4'h0;
  assign addr  = owner ? data_addr  : inst_addr;
  assign wdata = owner ? data_wdata : 32'h0;

  // Strays (data_ok in IDLE, or in REQ before acceptance) are dropped here.
  assign fwd_addr_ok = addr_ok & (state == REQ);
  assign fwd_data_ok = data_ok & (((state == REQ) & addr_ok) | (state == WAIT));

  assign inst_addr_ok = fwd_addr_ok & ~owner;
  assign inst_data_ok = fwd_data_ok & ~owner;
  assign data_addr_ok = fwd_addr_ok &  owner;
  assign data_data_ok = fwd_data_ok &  owner;

  assign inst_rdata = rdata;
  assign data_rdata = rdata;

endmodule
